// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the program/data RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 5;
  localparam int ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CPU,
    ARB_DBG,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_DBG
  } arb_port_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the RAM and the arbiter.
// master: requesters plus RAM read-data source; slave: the arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_locked;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the RAM arbiter.
// Optional macro MEM_ARB_CPU_PRIORITY_EN: CPU wins every unlocked conflict
// instead of round-robin on last_gnt.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic      cpu_req,
  input  logic      dbg_req,
  input  arb_port_t last_gnt,
  input  logic      locked,
  output logic      cpu_win,
  output logic      dbg_win
);

  // While locked only the loader may win; otherwise resolve conflicts.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (locked) begin
      dbg_win = dbg_req;
    end else begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      cpu_win = cpu_req;
      dbg_win = dbg_req & ~cpu_req;
`else
      if (cpu_req && dbg_req) begin
        cpu_win = (last_gnt == PORT_DBG);
        dbg_win = (last_gnt == PORT_CPU);
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req;
      end
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU and the debug/program loader.
// Grants are same-cycle; read data returns one cycle later to the owner.
// Optional macro MEM_ARB_CPU_PRIORITY_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state;
  arb_port_t         last_gnt;
  logic              locked;
  logic              cpu_win;
  logic              dbg_win;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              rvld_cpu_p1;
  logic              rvld_dbg_p1;
  logic              cpu_rvalid;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] cpu_rdata_hold;
  logic [DATA_W-1:0] dbg_rdata_hold;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  assign locked = (state == ARB_LOCKED);

  mem_arb_pick u_pick (
    .cpu_req  (bus.cpu_req),
    .dbg_req  (bus.dbg_req),
    .last_gnt (last_gnt),
    .locked   (locked),
    .cpu_win  (cpu_win),
    .dbg_win  (dbg_win)
  );

  // Reset masks grants and returning data in the same cycle it is asserted.
  assign cpu_gnt    = cpu_win & rst_n;
  assign dbg_gnt    = dbg_win & rst_n;
  assign cpu_rvalid = rvld_cpu_p1 & rst_n;
  assign dbg_rvalid = rvld_dbg_p1 & rst_n;

  // Steer the granted port onto the RAM; idle bus is all zero.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (cpu_gnt) begin
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
      we_mux    = bus.cpu_we;
    end else if (dbg_gnt) begin
      addr_mux  = bus.dbg_addr;
      wdata_mux = bus.dbg_wdata;
      we_mux    = bus.dbg_we;
    end
  end

  // Arbiter FSM, round-robin history and read-owner pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      last_gnt    <= PORT_DBG;
      rvld_cpu_p1 <= 1'b0;
      rvld_dbg_p1 <= 1'b0;
    end else begin
      // p0 -> p1: a granted read marks its owner for the RAM return cycle
      rvld_cpu_p1 <= cpu_gnt & ~bus.cpu_we;
      rvld_dbg_p1 <= dbg_gnt & ~bus.dbg_we;
      if (cpu_gnt) begin
        last_gnt <= PORT_CPU;
      end else if (dbg_gnt) begin
        last_gnt <= PORT_DBG;
      end
      if (locked) begin
        state <= bus.dbg_lock ? ARB_LOCKED : ARB_IDLE;
      end else if (dbg_gnt) begin
        state <= bus.dbg_lock ? ARB_LOCKED : ARB_DBG;
      end else if (cpu_gnt) begin
        state <= ARB_CPU;
      end else begin
        state <= ARB_IDLE;
      end
    end
  end

  // Capture returned words so each port's rdata holds between its reads.
  always_ff @(posedge clk) begin
    if (cpu_rvalid) begin
      cpu_rdata_hold <= bus.ram_rdata;
    end
    if (dbg_rvalid) begin
      dbg_rdata_hold <= bus.ram_rdata;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.ram_rdata : cpu_rdata_hold;
  assign bus.dbg_rdata  = dbg_rvalid ? bus.ram_rdata : dbg_rdata_hold;
  assign bus.dbg_locked = locked;
  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;
  assign bus.ram_we     = we_mux;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered 32x16 RAM model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 5;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [DW-1:0] mem [32];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, one-cycle latency, write-first not needed.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic lock);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
    bus.dbg_lock  = lock;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    mem[3] = 16'h1234;
    mem[4] = 16'h4444;
    bus.ram_rdata = '0;

    // Reset hold with a CPU write pending: nothing may reach the RAM.
    rst_n = 1'b0;
    drive_cpu(1'b1, 1'b1, 5'd5, 16'hFFFF);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rst_locked", bus.dbg_locked, 0);
    drive_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both request continuously after reset.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 5'd1, '0);
      drive_dbg(1'b1, 1'b0, 5'd2, '0, 1'b0);
      #1;
`ifdef MEM_ARB_CPU_PRIORITY_EN
      chk("rr_cpu_gnt", bus.cpu_gnt, 1);
      chk("rr_dbg_gnt", bus.dbg_gnt, 0);
`else
      chk("rr_cpu_gnt", bus.cpu_gnt, (k % 2 == 0) ? 1 : 0);
      chk("rr_dbg_gnt", bus.dbg_gnt, (k % 2 == 1) ? 1 : 0);
`endif
      if (k == 1) begin
        chk("rr_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("rr_cpu_rdata", bus.cpu_rdata, 16'h1111);
      end
    end
    do_reset();

    // CPU read of addr 3.
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 5'd3, '0);
    #1;
    chk("rd3_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd3_ram_addr", bus.ram_addr, 3);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, '0);
    #1;
    chk("rd3_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd3_cpu_rdata", bus.cpu_rdata, 16'h1234);
    chk("rd3_dbg_rvalid", bus.dbg_rvalid, 0);

    // Back-to-back reads to different owners.
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 5'd1, '0);
    #1;
    chk("b2b_cpu_gnt", bus.cpu_gnt, 1);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dbg(1'b1, 1'b0, 5'd2, '0, 1'b0);
    #1;
    chk("b2b_dbg_gnt", bus.dbg_gnt, 1);
    chk("b2b_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("b2b_cpu_rdata", bus.cpu_rdata, 16'h1111);
    chk("b2b_dbg_rvalid0", bus.dbg_rvalid, 0);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("b2b_dbg_rvalid", bus.dbg_rvalid, 1);
    chk("b2b_dbg_rdata", bus.dbg_rdata, 16'h2222);
    chk("b2b_cpu_rvalid1", bus.cpu_rvalid, 0);
    chk("b2b_cpu_hold", bus.cpu_rdata, 16'h1111);

    // CPU write, no read return.
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 5'd0, 16'h0001);
    #1;
    chk("wr_cpu_gnt", bus.cpu_gnt, 1);
    chk("wr_ram_we", bus.ram_we, 1);
    chk("wr_ram_wdata", bus.ram_wdata, 16'h0001);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, '0);
    #1;
    chk("wr_ram_we_off", bus.ram_we, 0);
    chk("wr_idle_addr", bus.ram_addr, 0);
    chk("wr_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("wr_dbg_rvalid", bus.dbg_rvalid, 0);
    @(negedge clk);
    drive_dbg(1'b1, 1'b0, 5'd0, '0, 1'b0);
    #1;
    chk("wr_rb_gnt", bus.dbg_gnt, 1);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("wr_rb_rvalid", bus.dbg_rvalid, 1);
    chk("wr_rb_rdata", bus.dbg_rdata, 16'h0001);

    // Locked download: loader write with lock, CPU shut out.
    @(negedge clk);
    drive_dbg(1'b1, 1'b1, 5'd7, 16'hBEEF, 1'b1);
    #1;
    chk("lk_dbg_gnt", bus.dbg_gnt, 1);
    chk("lk_ram_we", bus.ram_we, 1);
    chk("lk_ram_addr", bus.ram_addr, 7);
    chk("lk_ram_wdata", bus.ram_wdata, 16'hBEEF);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b1);
    drive_cpu(1'b1, 1'b0, 5'd4, '0);
    #1;
    chk("lk1_cpu_gnt", bus.cpu_gnt, 0);
    chk("lk1_locked", bus.dbg_locked, 1);
    @(negedge clk);
    drive_dbg(1'b1, 1'b0, 5'd7, '0, 1'b1);
    #1;
    chk("lk2_cpu_gnt", bus.cpu_gnt, 0);
    chk("lk2_dbg_gnt", bus.dbg_gnt, 1);
    chk("lk2_ram_addr", bus.ram_addr, 7);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    chk("lk3_cpu_gnt", bus.cpu_gnt, 0);
    chk("lk3_dbg_rvalid", bus.dbg_rvalid, 1);
    chk("lk3_dbg_rdata", bus.dbg_rdata, 16'hBEEF);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("lk4_cpu_gnt", bus.cpu_gnt, 0);
    chk("lk4_locked", bus.dbg_locked, 1);
    @(negedge clk);
    #1;
    chk("ul_locked", bus.dbg_locked, 0);
    chk("ul_cpu_gnt", bus.cpu_gnt, 1);
    chk("ul_ram_addr", bus.ram_addr, 4);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, '0);
    #1;
    chk("ul_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("ul_cpu_rdata", bus.cpu_rdata, 16'h4444);

    // Reset in the cycle after a granted, locking read.
    @(negedge clk);
    drive_dbg(1'b1, 1'b0, 5'd3, '0, 1'b1);
    #1;
    chk("rm_dbg_gnt", bus.dbg_gnt, 1);
    @(negedge clk);
    rst_n = 1'b0;
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("rm_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rm_cpu_rvalid", bus.cpu_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rm_state", 32'(dut.state), 32'(ARB_IDLE));
    chk("rm_locked", bus.dbg_locked, 0);
    chk("rm_dbg_rvalid1", bus.dbg_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
